spi_cmd_router: RTL
===================

Name: spi_cmd_router

Overview:
- Sits between the SPI slave deserializer and the GCD/Sobel cores inside the tt_um_sobel_gcd_unal top.
- Decodes each received 16-bit SPI word into one of three things: a GCD operand load, a readback poll, or a Sobel pixel word.
- Sequences the GCD start/done handshake.
- Buffers pixel words in a small FIFO and releases one word per Sobel enable request.

Parameters:
- OPERAND_WIDTH, 8, GCD operand width; taken from rx_word_i[OPERAND_WIDTH-1:0].
- FIFO_DEPTH, 4, pixel FIFO entries; must be a power of 2, at least 2.
- PX_WIDTH, 15, pixel payload width (rx_word_i[14:0]).

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous reset, active-high.
- rx_word_i  in  16  word from the SPI slave, already byte-reordered.
- rx_valid_i  in  1  one-cycle strobe; rx_word_i is valid on this cycle.
- gcd_en_i  in  1  external GCD enable level (pin).
- sobel_allowed_i  in  1  pixel words are accepted only while this is high.
- sobel_en_i  in  1  external Sobel enable; each rising edge requests one pixel.
- gcd_done_i  in  1  GCD core done pulse/level.
- gcd_result_i  in  OPERAND_WIDTH  GCD core result.
- gcd_a_o  out  OPERAND_WIDTH  operand A.
- gcd_b_o  out  OPERAND_WIDTH  operand B.
- gcd_start_o  out  1  one-cycle start pulse to the GCD core.
- px_data_o  out  PX_WIDTH  popped pixel word.
- px_valid_o  out  1  one-cycle pulse; px_data_o is valid.
- tx_word_o  out  16  reply word presented to the SPI slave for the next transfer.
- done_o  out  1  result available (drives uio_out[5]).
- status_o  out  4  {px_overflow, px_underflow, px_dropped, done}; the first three are sticky.

Behaviour:
- Reset: every output and register is 0, FSM is IDLE, FIFO is empty, edge detectors are cleared to 0.
- Reset mid-operation takes priority over everything else: the in-flight GCD is abandoned and the FIFO is flushed.
- Decode, evaluated on rx_valid_i only:
  - bit15=1: pixel word; payload rx_word_i[14:0].
  - bit15=0, bit13=1: load A <= rx_word_i[OPERAND_WIDTH-1:0] and set a_loaded.
  - bit15=0, bit13=0, word != 0: load B <= rx_word_i[OPERAND_WIDTH-1:0] and set b_loaded. B=0 therefore cannot be loaded.
  - word == 0x0000: poll/NOP; no register changes.
  - bit14 and bits above OPERAND_WIDTH in operand words are ignored.
- GCD FSM:
  - IDLE -> ARMED when a_loaded and b_loaded are both set.
  - ARMED -> START on a rising edge of gcd_en_i; a level already high on entry to ARMED does not count.
  - START lasts one cycle: gcd_start_o=1, then -> BUSY.
  - BUSY -> DONE on gcd_done_i=1: capture result; tx_word_o <= zero-extended result; done_o=1.
  - DONE -> IDLE on any operand load; that load clears done_o and both loaded flags before applying the new value.
  - Operand loads while in BUSY are ignored and set no flag.
  - gcd_en_i falling while in BUSY has no effect.
- Pixel path:
  - Push on a pixel word only when sobel_allowed_i=1 and the FIFO is not full.
  - Pixel word while sobel_allowed_i=0: dropped; sets px_dropped.
  - Pixel word while FIFO full: dropped; sets px_overflow.
  - Rising edge of sobel_en_i with FIFO not empty: pop; px_valid_o=1 for exactly one cycle, with px_data_o = head word, in the cycle after the edge is detected. px_data_o holds its value until the next pop.
  - Rising edge of sobel_en_i with FIFO empty: no pulse; sets px_underflow.
  - Push and pop in the same cycle: both occur and the count is unchanged. This is legal when the FIFO is full, since the pop frees the slot.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy count is log2(FIFO_DEPTH)+1 bits wide.
- Latency: edge detection uses one register stage, so the input pin to the output pulse is 2 clk_i cycles.
- status_o sticky bits clear only on reset.

Optional Feature:
- Macro: SPI_CMD_ECHO_EN.
- Defined: when not in DONE, tx_word_o = last rx_word_i, updated on each rx_valid_i. In DONE, tx_word_o = result.
- Undefined: tx_word_o = 0 outside DONE.

Test Plan:
- Load 0x2004 then 0x0008, then raise gcd_en_i -> gcd_a_o=0x04, gcd_b_o=0x08, a single gcd_start_o pulse. Model gcd_done_i with result 4 -> done_o=1, tx_word_o=0x0004.
- From DONE, send 0x2044 -> done_o clears and the FSM returns to IDLE. Send 0x0088, then toggle gcd_en_i 0->1 -> start pulse, gcd_a_o=0x44, gcd_b_o=0x88. Assert reset_i while in BUSY -> all outputs 0 on the next clock.
- With sobel_allowed_i=0, send 0xAAAA -> FIFO stays empty, status_o[1]=1 (px_dropped). With sobel_allowed_i=1, send 0xAAAA then pulse sobel_en_i for 2 cycles -> one px_valid_o pulse with px_data_o=0x2AAA, 2 cycles after the rising edge.
- Push 5 pixel words (0xAAAA, 0xA0A0, 0xABAB, 0x8001, 0x8002) with FIFO_DEPTH=4 -> the 5th is dropped and px_overflow=1. Four sobel_en_i pulses yield 0x2AAA, 0x20A0, 0x2BAB, 0x0001 in that order. A fifth pulse gives no px_valid_o and px_underflow=1.
- FIFO full, with a push and a sobel_en_i pop landing in the same cycle -> no overflow, count remains 4, and ordering is preserved across pointer wrap.
- 0x0000 poll in any state -> no register changes. With SPI_CMD_ECHO_EN defined, tx_word_o=0x0000 after the poll. Without the macro, tx_word_o=0 outside DONE.

Source files
------------

// File: rtl/spi_cmd_router.sv
// spi_cmd_router: decodes 16-bit SPI words into GCD operand loads, polls or
// Sobel pixel words. It sequences the GCD start/done handshake and buffers
// pixels in a small FIFO that releases one word per Sobel enable edge.
// Optional build macro: SPI_CMD_ECHO_EN. When it is defined, tx_word_o echoes
// the last received word outside DONE. When it is not defined, tx_word_o is 0
// outside DONE.
module spi_cmd_router #(
  parameter int OPERAND_WIDTH = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int PX_WIDTH      = 15
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [15:0]              rx_word_i,
  input  logic                     rx_valid_i,
  input  logic                     gcd_en_i,
  input  logic                     sobel_allowed_i,
  input  logic                     sobel_en_i,
  input  logic                     gcd_done_i,
  input  logic [OPERAND_WIDTH-1:0] gcd_result_i,
  output logic [OPERAND_WIDTH-1:0] gcd_a_o,
  output logic [OPERAND_WIDTH-1:0] gcd_b_o,
  output logic                     gcd_start_o,
  output logic [PX_WIDTH-1:0]      px_data_o,
  output logic                     px_valid_o,
  output logic [15:0]              tx_word_o,
  output logic                     done_o,
  output logic [3:0]               status_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ARMED, START, BUSY, DONE} state_t;

  state_t                   state_q;
  logic [OPERAND_WIDTH-1:0] a_q, b_q;
  logic                     a_loaded_q, b_loaded_q;
  logic                     start_q, done_q;
  logic [15:0]              tx_q;

  logic                     gcd_en_q, gcd_rise_q;
  logic                     sob_en_q, sob_rise_q;

  logic [PX_WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [AW:0]              count_q, count_d;
  logic [PX_WIDTH-1:0]      px_data_q;
  logic                     px_valid_q;
  logic                     ovf_q, unf_q, drop_q;

  // Word decode; a word of all zeros is a poll and matches none of these.
  logic is_px, ld_a, ld_b;
  assign is_px = rx_valid_i & rx_word_i[15];
  assign ld_a  = rx_valid_i & ~rx_word_i[15] & rx_word_i[13];
  assign ld_b  = rx_valid_i & ~rx_word_i[15] & ~rx_word_i[13] & (rx_word_i != 16'h0000);

  logic fifo_full, fifo_empty, push, pop;
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign pop        = sob_rise_q & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = is_px & sobel_allowed_i & (~fifo_full | pop);

  // Rising-edge detectors. The GCD edge only counts when it occurs while ARMED.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      gcd_en_q   <= 1'b0;
      gcd_rise_q <= 1'b0;
      sob_en_q   <= 1'b0;
      sob_rise_q <= 1'b0;
    end else begin
      gcd_en_q   <= gcd_en_i;
      gcd_rise_q <= gcd_en_i & ~gcd_en_q & (state_q == ARMED);
      sob_en_q   <= sobel_en_i;
      sob_rise_q <= sobel_en_i & ~sob_en_q;
    end
  end

  // GCD operand registers, handshake FSM and reply word.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      a_loaded_q <= 1'b0;
      b_loaded_q <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      tx_q       <= '0;
    end else begin
      start_q <= 1'b0;
`ifdef SPI_CMD_ECHO_EN
      if (rx_valid_i && (state_q != DONE)) tx_q <= rx_word_i;
`endif
      case (state_q)
        IDLE, ARMED: begin
          if (ld_a) begin
            a_q        <= rx_word_i[OPERAND_WIDTH-1:0];
            a_loaded_q <= 1'b1;
          end
          if (ld_b) begin
            b_q        <= rx_word_i[OPERAND_WIDTH-1:0];
            b_loaded_q <= 1'b1;
          end
          if (state_q == IDLE) begin
            if (a_loaded_q && b_loaded_q) state_q <= ARMED;
          end else if (gcd_rise_q) begin
            state_q <= START;
            start_q <= 1'b1;
          end
        end
        START: state_q <= BUSY;
        BUSY: begin
          if (gcd_done_i) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            tx_q    <= 16'(gcd_result_i);
          end
        end
        DONE: begin
          // A new operand starts a fresh sequence: flags clear, then this load applies.
          if (ld_a || ld_b) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            a_loaded_q <= ld_a;
            b_loaded_q <= ld_b;
            if (ld_a) a_q <= rx_word_i[OPERAND_WIDTH-1:0];
            if (ld_b) b_q <= rx_word_i[OPERAND_WIDTH-1:0];
`ifdef SPI_CMD_ECHO_EN
            tx_q <= rx_word_i;
`else
            tx_q <= '0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next occupancy; a simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Pixel FIFO storage, pop output register and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      px_data_q  <= '0;
      px_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      px_valid_q <= pop;
      if (push) begin
        mem_q[wr_ptr_q] <= rx_word_i[PX_WIDTH-1:0];
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        px_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      if (is_px && !sobel_allowed_i) drop_q <= 1'b1;
      if (is_px && sobel_allowed_i && fifo_full && !pop) ovf_q <= 1'b1;
      if (sob_rise_q && fifo_empty) unf_q <= 1'b1;
    end
  end

  assign gcd_a_o     = a_q;
  assign gcd_b_o     = b_q;
  assign gcd_start_o = start_q;
  assign px_data_o   = px_data_q;
  assign px_valid_o  = px_valid_q;
  assign tx_word_o   = tx_q;
  assign done_o      = done_q;
  assign status_o    = {ovf_q, unf_q, drop_q, done_q};

endmodule
